// File: rtl/rs_arith_pkg.sv
// rs_arith_pkg: shared types and constants for the soft-arith sequential divider.
//   state_t       - divider controller states (IDLE, BUSY, DONE, FIX)
//   count_width() - width of the quotient-bit counter for a given operand width
//   DBZ_*         - result constants for division by zero
// `MAX_CARRY_CHAIN bounds the legal operand width; it defaults to 64 when the
// build does not provide it.

`ifndef MAX_CARRY_CHAIN
`define MAX_CARRY_CHAIN 64
`endif

package rs_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam int MAX_CHAIN = `MAX_CARRY_CHAIN;

  // Quotient-bit counter runs WIDTH-1 down to 0.
  function automatic int count_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam logic [MAX_CHAIN-1:0] DBZ_QUOTIENT = '1;
  localparam logic                 DBZ_FLAG     = 1'b1;

endpackage

// File: rtl/rs_seq_divider_if.sv
// rs_seq_divider_if: operand/result handshake bundle for rs_seq_divider.
//   in_valid/in_ready   - operand handshake (dividend, divisor[, div_signed])
//   out_valid/out_ready - result handshake (quotient, remainder, div_by_zero)
// Modports: master (producer/consumer side), slave (divider side).
// RS_SEQ_DIVIDER_SIGNED_EN adds the div_signed operand qualifier.

interface rs_seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef RS_SEQ_DIVIDER_SIGNED_EN
  logic             div_signed;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
`ifdef RS_SEQ_DIVIDER_SIGNED_EN
    output div_signed,
`endif
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
`ifdef RS_SEQ_DIVIDER_SIGNED_EN
    input  div_signed,
`endif
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/rs_div_step.sv
// rs_div_step: one restoring-division trial subtract, a - {1'b0, b}, on a
// (WIDTH+1)-bit carry chain coded as a + ~b + 1.
//   a      - shifted partial remainder, WIDTH+1 bits
//   b      - divisor, WIDTH bits
//   diff   - low WIDTH bits of the difference (only meaningful when !borrow)
//   borrow - 1 when a < b

module rs_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] low_sum;

  // The divisor's top chain bit is always 0, so its inverted value is 1 and the
  // top cell collapses: carry_out = a[WIDTH] | carry_in. When there is no borrow
  // the true difference is below b and fits in WIDTH bits.
  always_comb begin
    low_sum = {1'b0, a[WIDTH-1:0]} + {1'b0, ~b} + (WIDTH+1)'(1);
    diff    = low_sum[WIDTH-1:0];
    borrow  = ~(a[WIDTH] | low_sum[WIDTH]);
  end

endmodule

// File: rtl/rs_seq_divider.sv
// rs_seq_divider: iterative restoring unsigned divider, one quotient bit per
// clock, valid/ready on both sides, one division in flight.
//   clk, rst - clock and synchronous active-high reset
//   bus      - rs_seq_divider_if slave: operands in, quotient/remainder/
//              div_by_zero out
// Divide by zero returns quotient all ones, remainder = dividend, after one cycle.
// Nonzero divisors take WIDTH cycles from the accepting edge to out_valid.
// RS_SEQ_DIVIDER_SIGNED_EN enables two's-complement division via div_signed
// and a FIX sign-correction state (latency WIDTH+1).

`ifndef MAX_CARRY_CHAIN
`define MAX_CARRY_CHAIN 64
`endif

module rs_seq_divider
  import rs_arith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  rs_seq_divider_if.slave bus
);

  localparam int CW = count_width(WIDTH);

  if (WIDTH < 3 || WIDTH > `MAX_CARRY_CHAIN) begin : g_width_check
    $error("rs_seq_divider: WIDTH %0d outside legal range 3..%0d", WIDTH, `MAX_CARRY_CHAIN);
  end

  state_t           state;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] divisor_r;
  logic [CW-1:0]    count;
  logic             out_valid_r;
  logic             dbz_r;
`ifdef RS_SEQ_DIVIDER_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] step_diff;
  logic             step_borrow;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Operand magnitudes; without the signed feature these are the raw operands.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
`ifdef RS_SEQ_DIVIDER_SIGNED_EN
    sign_a = bus.div_signed & bus.dividend[WIDTH-1];
    sign_b = bus.div_signed & bus.divisor[WIDTH-1];
`endif
    mag_a = sign_a ? (~bus.dividend + 1'b1) : bus.dividend;
    mag_b = sign_b ? (~bus.divisor  + 1'b1) : bus.divisor;
  end

  // Partial remainder shifted left with the next dividend bit, WIDTH+1 bits so
  // divisors with the MSB set are compared correctly.
  assign shifted = {rem_acc, q_acc[WIDTH-1]};

  rs_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a      (shifted),
    .b      (divisor_r),
    .diff   (step_diff),
    .borrow (step_borrow)
  );

  assign bus.in_ready    = (state == IDLE) && !rst;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = q_acc;
  assign bus.remainder   = rem_acc;
  assign bus.div_by_zero = dbz_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_acc     <= '0;
      q_acc       <= '0;
      divisor_r   <= '0;
      count       <= '0;
      out_valid_r <= 1'b0;
      dbz_r       <= 1'b0;
`ifdef RS_SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            if (bus.divisor == '0) begin
              q_acc       <= DBZ_QUOTIENT[WIDTH-1:0];
              rem_acc     <= bus.dividend;
              dbz_r       <= DBZ_FLAG;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              rem_acc   <= '0;
              q_acc     <= mag_a;
              divisor_r <= mag_b;
              count     <= CW'(WIDTH - 1);
              dbz_r     <= 1'b0;
`ifdef RS_SEQ_DIVIDER_SIGNED_EN
              neg_q     <= sign_a ^ sign_b;
              neg_r     <= sign_a;
`endif
              state     <= BUSY;
            end
          end
        end

        BUSY: begin
          rem_acc <= step_borrow ? shifted[WIDTH-1:0] : step_diff;
          q_acc   <= {q_acc[WIDTH-2:0], ~step_borrow};
          if (count == '0) begin
`ifdef RS_SEQ_DIVIDER_SIGNED_EN
            state       <= FIX;
`else
            out_valid_r <= 1'b1;
            state       <= DONE;
`endif
          end else begin
            count <= count - 1'b1;
          end
        end

`ifdef RS_SEQ_DIVIDER_SIGNED_EN
        // MIN / -1 needs no special case: the magnitude quotient is MIN's bit
        // pattern and the signs agree, so it passes through unchanged.
        FIX: begin
          if (neg_q) q_acc   <= ~q_acc + 1'b1;
          if (neg_r) rem_acc <= ~rem_acc + 1'b1;
          out_valid_r <= 1'b1;
          state       <= DONE;
        end
`endif

        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
